// File: rtl/systolic_mac_pe.sv
// Systolic-array processing element: forwards a/b east/south and computes a*b either
// chained onto the neighbour's partial sum or accumulated locally under a clear/drain FSM.
module systolic_mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  c,
    input  logic              clear,
    input  logic              drain,
    output logic [ACC_W-1:0]  out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              fwd_valid,
    output logic              ovf,
    output logic              busy
);

    generate
        if (ACC_W < 2 * DATA_W) begin : g_width_check
            $error("systolic_mac_pe: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    typedef enum logic {IDLE, ACC} state_t;

    state_t               state_reg;
    logic [ACC_W-1:0]     acc_reg;
    logic [2*DATA_W-1:0]  prod;
    logic [ACC_W-1:0]     prod_ext;
    logic [ACC_W:0]       chain_sum;
    logic [ACC_W:0]       acc_sum;
    logic [ACC_W-1:0]     chain_sat;
    logic [ACC_W-1:0]     acc_sat;

    // Sums carry one extra bit; a set carry clamps to all-ones.
    assign prod      = a * b;
    assign prod_ext  = ACC_W'(prod);
    assign chain_sum = {1'b0, c} + {1'b0, prod_ext};
    assign acc_sum   = {1'b0, acc_reg} + {1'b0, prod_ext};
    assign chain_sat = chain_sum[ACC_W] ? {ACC_W{1'b1}} : chain_sum[ACC_W-1:0];
    assign acc_sat   = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

    assign busy = (state_reg == ACC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            fwd_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_a     <= a;
            out_b     <= b;
            fwd_valid <= in_valid;
            out_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!mode) begin
                        if (in_valid) begin
                            out       <= chain_sat;
                            out_valid <= 1'b1;
                            if (chain_sum[ACC_W]) ovf <= 1'b1;
                        end
                    end else if (clear) begin
                        // The product cannot overflow, so the first term loads directly.
                        acc_reg   <= in_valid ? prod_ext : '0;
                        ovf       <= 1'b0;
                        state_reg <= ACC;
                    end
                end
                ACC: begin
                    // mode is deliberately not looked at here: it only matters in IDLE.
                    if (drain) begin
                        out       <= in_valid ? acc_sat : acc_reg;
                        out_valid <= 1'b1;
                        acc_reg   <= '0;
                        if (clear) begin
                            ovf <= 1'b0;
                        end else begin
                            if (in_valid && acc_sum[ACC_W]) ovf <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else if (clear) begin
                        acc_reg <= in_valid ? prod_ext : '0;
                        ovf     <= 1'b0;
                    end else if (in_valid) begin
                        acc_reg <= acc_sat;
                        if (acc_sum[ACC_W]) ovf <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Self-checking bench for systolic_mac_pe with DATA_W=8, ACC_W=16; expected results
// are queued on stimulus and compared when out_valid pulses.
module tb_systolic_mac_pe;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int MAXV = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] c;
    logic          clear;
    logic          drain;
    logic [AW-1:0] out;
    logic          out_valid;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic          fwd_valid;
    logic          ovf;
    logic          busy;

    int checks = 0;
    int failures = 0;
    logic [AW-1:0] exp_q[$];

    systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .clear(clear), .drain(drain),
        .out(out), .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
        .fwd_valid(fwd_valid), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every out_valid pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid: got out=%0d, required no out_valid", out);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                if (out !== e) begin
                    failures++;
                    $display("FAIL scoreboard_out: got %0d, required %0d", out, e);
                end else begin
                    $display("result out=%0d ok", out);
                end
            end
        end
    end

    function automatic int sat(input int x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic v, input int av, input int bv,
                         input int cv, input logic cl, input logic dr);
        mode = m; in_valid = v; a = DW'(av); b = DW'(bv); c = AW'(cv);
        clear = cl; drain = dr;
        step();
    endtask

    task automatic idle(input logic m);
        drive(m, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic flush(input string name);
        idle(mode);
        idle(mode);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending: got %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mode = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0; clear = 1'b0; drain = 1'b0;
        #3;
        checks++;
        if ({out, out_valid, out_a, out_b, fwd_valid, ovf, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got out=%0d ov=%b oa=%0d ob=%0d fv=%b ovf=%b busy=%b, required all 0",
                     out, out_valid, out_a, out_b, fwd_valid, ovf, busy);
        end
        step();
        step();
        rst = 1'b1;
        idle(1'b0);
        $display("reset check done");
    endtask

    task automatic test_chain();
        drive(1'b0, 1'b1, 12, 10, 5, 1'b0, 1'b0);
        exp_q.push_back(AW'(125));
        checks++;
        if (out_a !== 8'd12 || out_b !== 8'd10 || fwd_valid !== 1'b1) begin
            failures++;
            $display("FAIL chain_forward: got oa=%0d ob=%0d fv=%b, required 12 10 1", out_a, out_b, fwd_valid);
        end
        idle(1'b0);
        checks++;
        if (out !== AW'(125) || out_valid !== 1'b0 || fwd_valid !== 1'b0) begin
            failures++;
            $display("FAIL chain_hold: got out=%0d ov=%b fv=%b, required 125 0 0", out, out_valid, fwd_valid);
        end
        for (int i = 0; i < 5; i++) begin
            int av, bv, cv;
            av = $urandom_range(0, 255);
            bv = $urandom_range(0, 255);
            cv = $urandom_range(0, 2000);
            exp_q.push_back(AW'(sat(cv + av * bv)));
            drive(1'b0, 1'b1, av, bv, cv, 1'b0, 1'b0);
        end
        flush("chain");
    endtask

    task automatic test_stationary();
        drive(1'b1, 1'b1, 3, 4, 0, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL stat_busy_rise: got %b, required 1", busy);
        end
        drive(1'b1, 1'b1, 5, 6, 0, 1'b0, 1'b0);
        exp_q.push_back(AW'(98));
        drive(1'b1, 1'b1, 7, 8, 0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stat_drain_edge: got busy=%b ov=%b, required 0 1", busy, out_valid);
        end
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stat_idle_drain: got ov=%b, required 0", out_valid);
        end
        flush("stationary");
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1, 1, 0, 1'b1, 1'b0);
        exp_q.push_back(AW'(5));
        drive(1'b1, 1'b1, 2, 2, 0, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_stays: got %b, required 1", busy);
        end
        exp_q.push_back(AW'(9));
        drive(1'b1, 1'b1, 3, 3, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_fall: got %b, required 0", busy);
        end
        flush("back_to_back");
    endtask

    task automatic test_mode_lock();
        drive(1'b1, 1'b1, 2, 3, 0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4, 5, 100, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lock_no_chain: got busy=%b ov=%b, required 1 0", busy, out_valid);
        end
        exp_q.push_back(AW'(27));
        drive(1'b0, 1'b1, 1, 1, 0, 1'b0, 1'b1);
        flush("mode_lock");
    endtask

    task automatic test_saturation();
        exp_q.push_back(AW'(MAXV));
        drive(1'b0, 1'b1, 255, 255, MAXV, 1'b0, 1'b0);
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_chain_ovf: got %b, required 1", ovf);
        end
        exp_q.push_back(AW'(sat(10 + 3 * 3)));
        drive(1'b0, 1'b1, 3, 3, 10, 1'b0, 1'b0);
        idle(1'b0);
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_ovf_sticky: got %b, required 1", ovf);
        end
        drive(1'b1, 1'b1, 255, 255, 0, 1'b1, 1'b0);
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear_ovf: got %b, required 0", ovf);
        end
        drive(1'b1, 1'b1, 255, 255, 0, 1'b0, 1'b0);
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_acc_ovf: got %b, required 1", ovf);
        end
        exp_q.push_back(AW'(MAXV));
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        flush("saturation");
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 1'b1, 9, 9, 0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 200, 200, 0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({out, out_valid, out_a, out_b, fwd_valid, ovf, busy} !== '0) begin
            failures++;
            $display("FAIL reset_async: got out=%0d oa=%0d ob=%0d fv=%b ovf=%b busy=%b, required all 0",
                     out, out_a, out_b, fwd_valid, ovf, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_drain: got ov=%b busy=%b, required 0 0", out_valid, busy);
        end
        flush("reset_midstream");
    endtask

    initial begin
        test_reset();
        test_chain();
        test_stationary();
        test_back_to_back();
        test_mode_lock();
        test_saturation();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_mac_pe.md
# systolic_mac_pe

Parametrised processing element for the systolic matrix-multiply array, replacing the fixed 8-bit multiply-add cell. Each cycle it forwards its `a`/`b` operands and a valid flag to the east/south neighbours. It also computes `a*b` in one of two runtime modes:
- **Chain mode:** adds the product to the partial sum `c` from the neighbour (weight-/input-stationary arrays).
- **Stationary mode:** accumulates the product locally under a clear/drain state machine (output-stationary arrays).

Arithmetic is unsigned and saturating, with a sticky overflow flag.

## Interface
Parameters:
- `DATA_W`, default 8: width of the `a`, `b`, `out_a` and `out_b` operands.
- `ACC_W`, default 20: width of `c`, `out` and the accumulator. `ACC_W >= 2*DATA_W` is required; a violation is an elaboration error.

Ports (clock and reset first):
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `mode` input, 1 bit: 0 = chain MAC, 1 = stationary accumulate.
- `in_valid` input, 1 bit: `a`, `b` and `c` are valid this cycle.
- `a`, `b` input, `DATA_W` bits: multiplier operands.
- `c` input, `ACC_W` bits: incoming partial sum. Used only in chain mode.
- `clear` input, 1 bit: stationary mode; start a new accumulation.
- `drain` input, 1 bit: stationary mode; emit the accumulator.
- `out` output, `ACC_W` bits: result.
- `out_valid` output, 1 bit: `out` is new this cycle (one-cycle pulse).
- `out_a`, `out_b` output, `DATA_W` bits: registered `a` and `b`, for the neighbours.
- `fwd_valid` output, 1 bit: registered `in_valid`, accompanies `out_a`/`out_b`.
- `ovf` output, 1 bit: sticky saturation flag.
- `busy` output, 1 bit: high while the state machine is in ACC.

## Operation
Forwarding (all modes):
- `out_a <= a`, `out_b <= b`, `fwd_valid <= in_valid` every cycle, unconditionally.

Arithmetic:
- `p = a*b`, 2·`DATA_W` bits, zero-extended to `ACC_W`.
- Every sum `s = x + p` is computed at `ACC_W+1` bits.
- If the carry bit is set, the result is `2^ACC_W-1` and `ovf` is set.

Chain mode (`mode`=0):
- Valid only while the state machine is IDLE.
- `in_valid`=1: `out <= sat(c + p)`, `out_valid <= 1`.
- `in_valid`=0: `out` holds, `out_valid <= 0`.
- `clear` and `drain` are ignored.

Stationary mode (`mode`=1), states IDLE and ACC:
- IDLE, `clear`: `acc <= 0`, `ovf <= 0`, go to ACC. If `in_valid` is also high, `acc <= p` (the product is the first term).
- ACC, `in_valid`: `acc <= sat(acc + p)`.
- ACC, `drain`: `out <= sat(acc + p)` if `in_valid`, else `out <= acc`. Also `out_valid <= 1`, `acc <= 0`, go to IDLE.
- ACC, `drain` and `clear` together: drain as above, then restart. `acc <= 0`, `ovf` cleared, stay in ACC. `ovf` for the drained result is visible on `out_valid` cycle... no: `ovf` reflects the new accumulation.
- IDLE, `drain`: ignored; no `out_valid`.
- ACC, `clear` without `drain`: `acc <= 0` (plus `p` if `in_valid`), `ovf <= 0`, stay in ACC. The old sum is discarded.
- IDLE, `in_valid` without `clear`: ignored.

Mode switching:
- `mode` is sampled only in IDLE. A change while in ACC has no effect until the FSM returns to IDLE.
- Chain-mode behaviour is suppressed while `busy`=1.

`ovf` clearing:
- Cleared only by reset or by a stationary-mode `clear`.
- In chain mode it accumulates across results.

## Timing
- Reset (`rst`=0, asynchronous): `out`=0, `out_valid`=0, `out_a`=0, `out_b`=0, `fwd_valid`=0, `ovf`=0, `busy`=0, acc=0, state IDLE. Effective immediately, without waiting for a clock edge.
- Reset mid-accumulation discards `acc`; no `out_valid` is emitted.
- Forwarding latency: 1 cycle.
- Chain result latency: 1 cycle from the `in_valid` edge.
- Drain latency: 1 cycle from the `drain` edge.
- Back-to-back drains (drain+clear, then drain N cycles later) are supported. No dead cycle is required between accumulations.
- `busy` rises the cycle after `clear` and falls the cycle after `drain`.
- Single-cycle combinational path: multiplier plus adder.

## Test plan
- Reset: assert `rst`=0 mid-stream, asynchronously between edges → all outputs are 0 at once. After release, the first `drain` produces no `out_valid`.
- Chain: `mode`=0, `a`=12, `b`=10, `c`=5, `in_valid`=1 → next cycle `out`=125, `out_valid`=1; `out_a`=12, `out_b`=10, `fwd_valid`=1.
- Stationary:
  - `mode`=1, `clear` with (3,4), then (5,6) and (7,8) on consecutive cycles, with `drain` on the (7,8) cycle → `out`=12+30+56=98, a single `out_valid` pulse; `busy` falls the next cycle.
  - Drain+clear together with a product of 2·2 in the same cycle → drained value includes the 4. `acc` restarts at 0, `busy` stays 1.
- Saturation: `DATA_W`=8, `ACC_W`=16, `mode`=0, `a`=`b`=255, `c`=0xFFFF → `out`=0xFFFF, `ovf`=1. `ovf` stays 1 through later non-overflowing results.
- Mode lock: switch `mode` to 0 while in ACC, with `in_valid` pulses → no chain `out_valid`. Accumulation continues, and the drain yields the correct sum.
